// File: rtl/sram_ctrl.sv
// Purpose : single-word read/write controller for an asynchronous SRAM (CS_N/WE_N/OE_N, shared data bus).
// Latency : read response pulse WAIT_CYCLES+1 cycles after the request cycle; a write occupies WAIT_CYCLES+2 cycles.
// Backpress: req_ready_o is low while an access is in flight; rsp_valid_o has no backpressure.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), asynchronous active-high reset
//   req_valid_i / req_ready_o    request handshake; req_we_i, req_addr_i, req_wdata_i latched on accept
//   rsp_valid_o / rsp_rdata_o    one-cycle read response pulse; read data held until the next read completes
//   sram_cs_no/we_no/oe_no       active-low SRAM strobes (registered)
//   sram_addr_o, sram_data_o     SRAM address and write data (registered, held in IDLE)
//   sram_data_oe_o               1 = controller drives the data bus
//   sram_data_i                  data bus as seen from the SRAM
module sram_ctrl #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  sram_cs_no,
    output logic                  sram_we_no,
    output logic                  sram_oe_no,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_data_o,
    output logic                  sram_data_oe_o,
    input  logic [DATA_WIDTH-1:0] sram_data_i
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_cs_n;
    logic                  r_we_n;
    logic                  r_oe_n;
    logic                  r_data_oe;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  w_cnt_done;

    assign w_cnt_done = (r_cnt == '0);

    // Strobes are produced on the transition into each state so every
    // SRAM pin comes straight from a flop; the address/data registers
    // double as the latched copy of the accepted request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cs_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_data_oe   <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_cnt  <= CNT_LOAD;
                        r_addr <= req_addr_i;
                        r_cs_n <= 1'b0;
                        if (req_we_i) begin
                            r_data    <= req_wdata_i;
                            r_data_oe <= 1'b1;
                            r_state   <= WR_SETUP;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    if (w_cnt_done) begin
                        r_rsp_rdata <= sram_data_i;
                        r_rsp_valid <= 1'b1;
                        r_cs_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WR_SETUP: begin
                    // Address and data have been stable for a full cycle
                    // before WE_N falls.
                    r_we_n  <= 1'b0;
                    r_state <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (w_cnt_done) begin
                        r_we_n  <= 1'b1;
                        r_state <= WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WR_HOLD: begin
                    // Data stays driven one cycle past WE_N rising.
                    r_cs_n    <= 1'b1;
                    r_data_oe <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_cs_n    <= 1'b1;
                    r_we_n    <= 1'b1;
                    r_oe_n    <= 1'b1;
                    r_data_oe <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = (r_state == IDLE);
    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_rdata_o    = r_rsp_rdata;
    assign sram_cs_no     = r_cs_n;
    assign sram_we_no     = r_we_n;
    assign sram_oe_no     = r_oe_n;
    assign sram_addr_o    = r_addr;
    assign sram_data_o    = r_data;
    assign sram_data_oe_o = r_data_oe;

endmodule

// File: tb/tb_sram_ctrl.sv
// Purpose : self-checking bench for sram_ctrl at WAIT_CYCLES = 2 (main), 1 and 5.
// Latency : n/a (bench).
// Backpress: n/a (bench).
module tb_sram_ctrl;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    // main instance, WAIT_CYCLES = 2
    logic          m_ready, m_rsp_vld, m_cs_n, m_we_n, m_oe_n, m_doe;
    logic [DW-1:0] m_rdata, m_data, m_din;
    logic [AW-1:0] m_addr;
    // WAIT_CYCLES = 1
    logic          a_ready, a_rsp_vld, a_cs_n, a_we_n, a_oe_n, a_doe;
    logic [DW-1:0] a_rdata, a_data, a_din;
    logic [AW-1:0] a_addr;
    // WAIT_CYCLES = 5
    logic          b_ready, b_rsp_vld, b_cs_n, b_we_n, b_oe_n, b_doe;
    logic [DW-1:0] b_rdata, b_data, b_din;
    logic [AW-1:0] b_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) u_m (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(m_ready),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(m_rsp_vld), .rsp_rdata_o(m_rdata),
        .sram_cs_no(m_cs_n), .sram_we_no(m_we_n), .sram_oe_no(m_oe_n),
        .sram_addr_o(m_addr), .sram_data_o(m_data), .sram_data_oe_o(m_doe),
        .sram_data_i(m_din));

    sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(1)) u_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(a_ready),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(a_rsp_vld), .rsp_rdata_o(a_rdata),
        .sram_cs_no(a_cs_n), .sram_we_no(a_we_n), .sram_oe_no(a_oe_n),
        .sram_addr_o(a_addr), .sram_data_o(a_data), .sram_data_oe_o(a_doe),
        .sram_data_i(a_din));

    sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(5)) u_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(b_ready),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(b_rsp_vld), .rsp_rdata_o(b_rdata),
        .sram_cs_no(b_cs_n), .sram_we_no(b_we_n), .sram_oe_no(b_oe_n),
        .sram_addr_o(b_addr), .sram_data_o(b_data), .sram_data_oe_o(b_doe),
        .sram_data_i(b_din));

    // SRAM model for the main instance: write while CS/WE low with bus driven.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(negedge clk) begin
        if (!m_cs_n && !m_we_n && m_doe) mem[m_addr] <= m_data;
    end
    assign m_din = (!m_cs_n && !m_oe_n) ? mem[m_addr] : 8'h00;

    // Secondary instances read a fixed pattern: addr[7:0] ^ 0x5A.
    assign a_din = (!a_cs_n && !a_oe_n) ? (a_addr[7:0] ^ 8'h5A) : 8'h00;
    assign b_din = (!b_cs_n && !b_oe_n) ? (b_addr[7:0] ^ 8'h5A) : 8'h00;

    // Last completed low-pulse widths for the secondary instances.
    int a_we_run = 0, a_we_w = 0, a_oe_run = 0, a_oe_w = 0;
    int b_we_run = 0, b_we_w = 0, b_oe_run = 0, b_oe_w = 0;
    always @(negedge clk) begin
        if (!a_we_n) a_we_run <= a_we_run + 1;
        else if (a_we_run != 0) begin a_we_w <= a_we_run; a_we_run <= 0; end
        if (!a_oe_n) a_oe_run <= a_oe_run + 1;
        else if (a_oe_run != 0) begin a_oe_w <= a_oe_run; a_oe_run <= 0; end
        if (!b_we_n) b_we_run <= b_we_run + 1;
        else if (b_we_run != 0) begin b_we_w <= b_we_run; b_we_run <= 0; end
        if (!b_oe_n) b_oe_run <= b_oe_run + 1;
        else if (b_oe_run != 0) begin b_oe_w <= b_oe_run; b_oe_run <= 0; end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge and check bus contention on every instance.
    task automatic tick();
        @(negedge clk);
        chk("contention_m", 32'(!m_oe_n && m_doe), 0);
        chk("contention_a", 32'(!a_oe_n && a_doe), 0);
        chk("contention_b", 32'(!b_oe_n && b_doe), 0);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
    } vec_t;

    // One access on the main instance; cycle k = k-th cycle after the request cycle.
    task automatic do_access(input vec_t v, input int n);
        int we_low = 0, oe_low = 0, first_we = 0, rsp_cyc = 0, rdy_cyc = 0, bad_bus = 0;
        int rdy1 = 1;
        logic [DW-1:0] rd = '0;
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wd;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                req_valid = 1'b0; req_we = ~v.we; req_addr = ~v.addr; req_wdata = ~v.wd;
                rdy1 = 32'(m_ready);
            end
            if (!m_we_n) begin we_low++; if (first_we == 0) first_we = k; end
            if (!m_oe_n) oe_low++;
            if (m_rsp_vld) begin if (rsp_cyc == 0) rsp_cyc = k; rd = m_rdata; end
            if (m_ready && rdy_cyc == 0) rdy_cyc = k;
            if (!m_cs_n && (m_addr !== v.addr || m_doe !== v.we || (v.we && m_data !== v.wd)))
                bad_bus++;
        end
        chk($sformatf("v%0d_busy_after_accept", n), rdy1, 0);
        chk($sformatf("v%0d_bus_stable", n), bad_bus, 0);
        if (v.we) begin
            chk($sformatf("v%0d_we_first_cycle", n), first_we, 2);
            chk($sformatf("v%0d_we_low_cycles", n), we_low, 2);
            chk($sformatf("v%0d_oe_low_cycles", n), oe_low, 0);
            chk($sformatf("v%0d_no_rsp", n), rsp_cyc, 0);
            chk($sformatf("v%0d_ready_cycle", n), rdy_cyc, 5);
            chk($sformatf("v%0d_mem", n), 32'(mem[v.addr]), 32'(v.wd));
        end else begin
            chk($sformatf("v%0d_oe_low_cycles", n), oe_low, 2);
            chk($sformatf("v%0d_we_low_cycles", n), we_low, 0);
            chk($sformatf("v%0d_rsp_cycle", n), rsp_cyc, 3);
            chk($sformatf("v%0d_rdata", n), 32'(rd), 32'(v.exp_rd));
            chk($sformatf("v%0d_ready_cycle", n), rdy_cyc, 3);
        end
    endtask

    vec_t vecs [8];

    initial begin
        int idx, nrsp, doe_seen, seen_oe, gap, gap_at_doe, doe_start, rsp_m, rsp_b;
        int rcyc [3];
        logic [DW-1:0] rdat [3];
        vec_t ops [2];

        vecs[0] = '{1'b1, 14'h0123, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 14'h0123, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 14'h0000, 8'h11, 8'h00};
        vecs[3] = '{1'b1, 14'h0001, 8'h22, 8'h00};
        vecs[4] = '{1'b1, 14'h0002, 8'h33, 8'h00};
        vecs[5] = '{1'b0, 14'h0001, 8'h00, 8'h22};
        vecs[6] = '{1'b1, 14'h3FFF, 8'hFF, 8'h00};
        vecs[7] = '{1'b0, 14'h3FFF, 8'h00, 8'hFF};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

        // reset state
        tick(); tick();
        chk("rst_cs_n", 32'(m_cs_n), 1);
        chk("rst_we_n", 32'(m_we_n), 1);
        chk("rst_oe_n", 32'(m_oe_n), 1);
        chk("rst_data_oe", 32'(m_doe), 0);
        chk("rst_addr", 32'(m_addr), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_rsp_valid", 32'(m_rsp_vld), 0);
        chk("rst_rsp_rdata", 32'(m_rdata), 0);
        rst = 1'b0;
        tick(); tick();
        chk("idle_ready", 32'(m_ready), 1);
        chk("idle_strobes", 32'({m_cs_n, m_we_n, m_oe_n}), 7);
        chk("idle_data_oe", 32'(m_doe), 0);
        chk("idle_rsp_valid", 32'(m_rsp_vld), 0);

        for (int i = 0; i < 8; i++) do_access(vecs[i], i);

        // back-to-back reads with req_valid held high
        idx = 0; nrsp = 0; doe_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (m_ready) begin
                if (idx < 3) begin req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(idx); idx++; end
                else req_valid = 1'b0;
            end
            tick();
            if (m_doe) doe_seen = 1;
            if (m_rsp_vld && nrsp < 3) begin rcyc[nrsp] = c; rdat[nrsp] = m_rdata; nrsp++; end
        end
        req_valid = 1'b0;
        tick();
        chk("b2b_rsp_count", nrsp, 3);
        chk("b2b_first_rsp_cycle", rcyc[0], 2);
        chk("b2b_spacing_1", rcyc[1] - rcyc[0], 3);
        chk("b2b_spacing_2", rcyc[2] - rcyc[1], 3);
        chk("b2b_rdata_0", 32'(rdat[0]), 32'h11);
        chk("b2b_rdata_1", 32'(rdat[1]), 32'h22);
        chk("b2b_rdata_2", 32'(rdat[2]), 32'h33);
        chk("b2b_no_data_oe", doe_seen, 0);

        // read immediately followed by a write: turnaround cycle required
        ops[0] = '{1'b0, 14'h0002, 8'h00, 8'h33};
        ops[1] = '{1'b1, 14'h0004, 8'h9C, 8'h00};
        idx = 0; nrsp = 0; seen_oe = 0; gap = 0; gap_at_doe = 0; doe_start = 0;
        for (int c = 0; c < 12; c++) begin
            if (m_ready) begin
                if (idx < 2) begin
                    req_valid = 1'b1; req_we = ops[idx].we; req_addr = ops[idx].addr;
                    req_wdata = ops[idx].wd; idx++;
                end else req_valid = 1'b0;
            end
            tick();
            if (!m_oe_n) seen_oe = 1;
            if (seen_oe != 0 && m_oe_n && !m_doe) gap = 1;
            if (m_doe && doe_start == 0) begin doe_start = 1; gap_at_doe = gap; end
            if (m_rsp_vld && nrsp == 0) begin rdat[0] = m_rdata; nrsp++; end
        end
        req_valid = 1'b0;
        chk("rw_read_rdata", 32'(rdat[0]), 32'h33);
        chk("rw_write_started", doe_start, 1);
        chk("rw_turnaround_gap", gap_at_doe, 1);
        chk("rw_mem", 32'(mem[14'h0004]), 32'h9C);
        do_access('{1'b0, 14'h0004, 8'h00, 8'h9C}, 8);

        // pulse widths and read data for WAIT_CYCLES = 1 and 5
        req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h0010; req_wdata = 8'h66;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("w1_we_width", a_we_w, 1);
        chk("w5_we_width", b_we_w, 5);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 14'h0042;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        chk("w1_oe_width", a_oe_w, 1);
        chk("w5_oe_width", b_oe_w, 5);
        chk("w1_rdata", 32'(a_rdata), 32'h18);
        chk("w5_rdata", 32'(b_rdata), 32'h18);

        // reset asserted during WR_PULSE: strobes release without a clock edge
        req_valid = 1'b1; req_we = 1'b1; req_addr = 14'h0055; req_wdata = 8'h77;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_w2_we_low", 32'(m_we_n), 0);
        chk("mid_w1_we_low", 32'(a_we_n), 0);
        chk("mid_w5_we_low", 32'(b_we_n), 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_w2_strobes", 32'({m_cs_n, m_we_n, m_oe_n}), 7);
        chk("arst_w2_data_oe", 32'(m_doe), 0);
        chk("arst_w1_strobes", 32'({a_cs_n, a_we_n, a_oe_n}), 7);
        chk("arst_w5_strobes", 32'({b_cs_n, b_we_n, b_oe_n}), 7);
        chk("arst_w5_data_oe", 32'(b_doe), 0);
        tick();
        rst = 1'b0;
        rsp_m = 0; rsp_b = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (m_rsp_vld) rsp_m++;
            if (b_rsp_vld) rsp_b++;
        end
        chk("arst_no_rsp_w2", rsp_m, 0);
        chk("arst_no_rsp_w5", rsp_b, 0);
        chk("arst_ready_w2", 32'(m_ready), 1);
        chk("arst_ready_w5", 32'(b_ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
